// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the reg_file_sweep register array.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Address width for a given depth; never below one bit.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_sweep_entry.sv
// One storage entry of the register array: synchronous reset, zero beats load.
module reg_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             zero,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (zero) q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/reg_file_sweep.sv
// DEPTH x WIDTH register file, one write port, two combinational reads, sequenced clear.
// Optional same-cycle write-through on reads when REG_FILE_BYPASS_EN is defined.
module reg_file_sweep
  import reg_file_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              clr,
  output logic [WIDTH-1:0]  r_a,
  output logic [WIDTH-1:0]  r_b,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  cnt;
  logic               cnt_last;
  logic               sweeping;
  logic               wr_ok;
  logic [WIDTH-1:0]   q [DEPTH];

  assign cnt_last = (cnt == LAST_IDX);
  // Writes are only taken while idle and to an existing entry.
  assign wr_ok    = (state == IDLE) && ena && ({1'b0, waddr} < DEPTH_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR && !cnt_last) cnt <= cnt + ADDR_W'(1);
      else                             cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr)      state_nxt = CLEAR;
      CLEAR:   if (cnt_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sweeping = (state == CLEAR);
    busy     = sweeping;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    reg_entry #(.WIDTH(WIDTH)) u_entry (
      .clk  (clk),
      .rst  (rst),
      .load (wr_ok && (waddr == ADDR_W'(i))),
      .zero (sweeping && (cnt == ADDR_W'(i))),
      .d    (data),
      .q    (q[i])
    );
  end

  // Out-of-range addresses match no entry and so read zero.
  always_comb begin
    r_a = '0;
    r_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) r_a = q[i];
      if (raddr_b == ADDR_W'(i)) r_b = q[i];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && (raddr_a == waddr)) r_a = data;
    if (wr_ok && (raddr_b == waddr)) r_b = data;
`endif
  end

endmodule

// File: tb/tb_reg_file_sweep.sv
// Directed bench for reg_file_sweep: an 8-deep and a 5-deep instance share clock and reset.
module tb_reg_file_sweep;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena, clr;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [7:0] data, r_a, r_b;
  logic       busy;

  logic       b_ena;
  logic [2:0] b_waddr, b_raddr_a, b_raddr_b;
  logic [7:0] b_data, b_r_a, b_r_b;
  logic       b_busy;

  int total = 0;
  int bad   = 0;
  int cycles;

  always #5 clk = ~clk;

  reg_file_sweep #(.WIDTH(8), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .waddr(waddr), .data(data),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .clr(clr),
    .r_a(r_a), .r_b(r_b), .busy(busy)
  );

  reg_file_sweep #(.WIDTH(8), .DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst), .ena(b_ena), .waddr(b_waddr), .data(b_data),
    .raddr_a(b_raddr_a), .raddr_b(b_raddr_b), .clr(1'b0),
    .r_a(b_r_a), .r_b(b_r_b), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write8(input logic [2:0] a, input logic [7:0] d);
    ena = 1'b1; waddr = a; data = d;
    tick();
    ena = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; clr = 1'b0; waddr = '0; data = '0;
    raddr_a = '0; raddr_b = 3'd7;
    b_ena = 1'b0; b_waddr = '0; b_data = '0; b_raddr_a = '0; b_raddr_b = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_ra0", r_a, 8'h00);
    check("reset_rb7", r_b, 8'h00);
    check("reset_busy_d5", b_busy, 0);

    // Basic write and read-after-write timing
    ena = 1'b1; waddr = 3'd3; data = 8'hA5; raddr_a = 3'd3; raddr_b = 3'd2;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("wr3_same_cycle", r_a, 8'hA5);
`else
    check("wr3_same_cycle", r_a, 8'h00);
`endif
    tick();
    ena = 1'b0; data = 8'hEE;
    #1;
    check("wr3_next_cycle", r_a, 8'hA5);
    check("rd2_zero", r_b, 8'h00);
    tick();
    #1;
    check("hold_ena0", r_a, 8'hA5);

    // Fill all entries
    for (int k = 0; k < 8; k++) write8(3'(k), 8'h10 + 8'(k));
    #1;
    for (int k = 0; k < 8; k++) begin
      raddr_a = 3'(k);
      #1;
      check("fill_read", r_a, 8'h10 + 8'(k));
    end

    // Overwrite entry 2: bypass vs stored value in the write cycle
    ena = 1'b1; waddr = 3'd2; data = 8'hC3; raddr_a = 3'd2;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("byp_same_cycle", r_a, 8'hC3);
`else
    check("old_same_cycle", r_a, 8'h12);
`endif
    tick();
    ena = 1'b0;
    #1;
    check("wr2_next_cycle", r_a, 8'hC3);

    // Full sweep with a dropped write and an ignored clr mid-sweep
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      raddr_a = 3'(cycles);
      raddr_b = 3'(cycles - 1);
      if (cycles == 3) begin
        ena = 1'b1; waddr = 3'd7; data = 8'hFF; clr = 1'b1;
      end else begin
        ena = 1'b0; clr = 1'b0;
      end
      #1;
      check("sweep_pending", r_a, (cycles == 2) ? 8'hC3 : 8'h10 + 8'(cycles));
      if (cycles > 0) check("sweep_cleared", r_b, 8'h00);
      cycles++;
      tick();
    end
    ena = 1'b0; clr = 1'b0;
    check("sweep_len", cycles, 8);
    for (int k = 0; k < 8; k++) begin
      raddr_a = 3'(k);
      #1;
      check("after_sweep", r_a, 8'h00);
    end
    tick();
    #1;
    check("no_restart", busy, 0);

    // Same-edge write and clear request
    ena = 1'b1; clr = 1'b1; waddr = 3'd0; data = 8'h55; raddr_a = 3'd0;
    tick();
    ena = 1'b0; clr = 1'b0;
    #1;
    check("clrwr_busy", busy, 1);
    check("clrwr_written", r_a, 8'h55);
    tick();
    #1;
    check("clrwr_cleared", r_a, 8'h00);
    cycles = 0;
    while (busy && cycles < 20) begin
      cycles++;
      tick();
    end
    check("clrwr_sweep_end", busy, 0);

    // Reset in the middle of a sweep
    for (int k = 0; k < 8; k++) write8(3'(k), 8'h20 + 8'(k));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick(); tick(); tick();
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    for (int k = 0; k < 8; k++) begin
      raddr_a = 3'(k);
      #1;
      check("rst_mid_zero", r_a, 8'h00);
    end
    write8(3'd5, 8'h3C);
    raddr_b = 3'd5;
    #1;
    check("post_rst_write", r_b, 8'h3C);
    check("post_rst_idle", busy, 0);

    // Non-power-of-two depth: out-of-range reads and writes
    b_ena = 1'b1; b_waddr = 3'd6; b_data = 8'h77; b_raddr_a = 3'd6;
    #1;
    check("d5_oor_same_cycle", b_r_a, 8'h00);
    tick();
    b_waddr = 3'd4; b_data = 8'h44;
    tick();
    b_ena = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b_raddr_a = 3'(k);
      #1;
      check("d5_read", b_r_a, (k == 4) ? 8'h44 : 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
